// File: rtl/clock_group_reset_sequencer.sv
// Clock-enable / reset sequencer for subsystem_sbus and subsystem_l2.
// Ports: clock, reset (sync, active-low), cmd_valid/cmd_off/cmd_ready
//   (l2 power command), done (completion pulse), sbus_clk_en,
//   sbus_reset, l2_clk_en, l2_reset (active-high), state (FSM code).
// Optional l2 power gating: define CLOCK_GROUP_SEQ_L2_GATING_EN.
module clock_group_reset_sequencer #(
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4,
   parameter int CNT_W       = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic       cmd_off,
   output logic       cmd_ready,
   output logic       done,
   output logic       sbus_clk_en,
   output logic       sbus_reset,
   output logic       l2_clk_en,
   output logic       l2_reset,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      HOLD    = 3'd0,
      SBUS_UP = 3'd1,
      RUN     = 3'd2,
      L2_DOWN = 3'd3,
      OFF     = 3'd4,
      L2_UP   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sbus_clk_en_q, sbus_clk_en_d;
   logic             sbus_reset_q, sbus_reset_d;
   logic             l2_clk_en_q, l2_clk_en_d;
   logic             l2_reset_q, l2_reset_d;
   logic             done_q, done_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= HOLD;
         cnt_q         <= '0;
         sbus_clk_en_q <= 1'b0;
         sbus_reset_q  <= 1'b1;
         l2_clk_en_q   <= 1'b0;
         l2_reset_q    <= 1'b1;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sbus_clk_en_q <= sbus_clk_en_d;
         sbus_reset_q  <= sbus_reset_d;
         l2_clk_en_q   <= l2_clk_en_d;
         l2_reset_q    <= l2_reset_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + CNT_ONE;
      sbus_clk_en_d = sbus_clk_en_q;
      sbus_reset_d  = sbus_reset_q;
      l2_clk_en_d   = l2_clk_en_q;
      l2_reset_d    = l2_reset_q;
      done_d        = 1'b0;
      case (state_q)
         HOLD: begin
            // Clocks still off means this is the first edge out of
            // reset: start the clocks and restart the hold count here.
            if (!sbus_clk_en_q) begin
               sbus_clk_en_d = 1'b1;
               l2_clk_en_d   = 1'b1;
               cnt_d         = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d      = SBUS_UP;
               sbus_reset_d = 1'b0;
               cnt_d        = '0;
            end
         end
         SBUS_UP: begin
            if (cnt_q == GAP_LAST) begin
               state_d    = RUN;
               l2_reset_d = 1'b0;
               cnt_d      = '0;
            end
         end
         RUN: begin
`ifdef CLOCK_GROUP_SEQ_L2_GATING_EN
            if (cmd_valid) begin
               if (cmd_off) begin
                  state_d    = L2_DOWN;
                  l2_reset_d = 1'b1;
                  cnt_d      = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
`endif
         end
`ifdef CLOCK_GROUP_SEQ_L2_GATING_EN
         L2_DOWN: begin
            if (cnt_q == GAP_LAST) begin
               state_d     = OFF;
               l2_clk_en_d = 1'b0;
               done_d      = 1'b1;
               cnt_d       = '0;
            end
         end
         OFF: begin
            if (cmd_valid) begin
               if (!cmd_off) begin
                  state_d     = L2_UP;
                  l2_clk_en_d = 1'b1;
                  cnt_d       = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         L2_UP: begin
            if (cnt_q == HOLD_LAST) begin
               state_d    = RUN;
               l2_reset_d = 1'b0;
               done_d     = 1'b1;
               cnt_d      = '0;
            end
         end
`endif
         default: begin
            state_d       = HOLD;
            cnt_d         = '0;
            sbus_clk_en_d = 1'b1;
            sbus_reset_d  = 1'b1;
            l2_clk_en_d   = 1'b1;
            l2_reset_d    = 1'b1;
         end
      endcase
   end

`ifdef CLOCK_GROUP_SEQ_L2_GATING_EN
   assign cmd_ready = (state_q == RUN) || (state_q == OFF);
   assign done      = done_q;
`else
   logic unused_cmd;
   logic unused_done;
   assign unused_cmd  = cmd_valid ^ cmd_off;
   assign unused_done = done_q;
   assign cmd_ready   = 1'b0;
   assign done        = 1'b0;
`endif

   assign sbus_clk_en = sbus_clk_en_q;
   assign sbus_reset  = sbus_reset_q;
   assign l2_clk_en   = l2_clk_en_q;
   assign l2_reset    = l2_reset_q;
   assign state       = state_q;

endmodule
